// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: preamble 1s, SOF 0, data LSB first, optional even parity, stop 1.
// Define SERIAL_FRAME_TX_PARITY_EN to compile in the parity bit.
module serial_frame_tx #(
    parameter int DATA_W  = 8,
    parameter int PRE_LEN = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              x_out,
    output logic              done
);

    localparam int MAX_LEN = (DATA_W > PRE_LEN) ? DATA_W : PRE_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SOF,
        S_DATA,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              parity_bit;
`endif

    // The state register names the bit currently on x_out, so every output
    // is set on the edge that enters the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            x_out     <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shift_reg <= data_in;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                        bit_cnt   <= PRE_LAST;
                        state     <= S_PRE;
                        x_out     <= 1'b1;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                S_PRE: begin
                    if (bit_cnt == '0) begin
                        state   <= S_SOF;
                        bit_cnt <= '0;
                        x_out   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end

                S_SOF: begin
                    state     <= S_DATA;
                    bit_cnt   <= DATA_LAST;
                    x_out     <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                end

                S_DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state   <= S_PAR;
                        x_out   <= parity_bit;
`else
                        state   <= S_STOP;
                        x_out   <= 1'b1;
`endif
                    end else begin
                        bit_cnt   <= bit_cnt - CNT_ONE;
                        x_out     <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end

`ifdef SERIAL_FRAME_TX_PARITY_EN
                S_PAR: begin
                    state   <= S_STOP;
                    bit_cnt <= '0;
                    x_out   <= 1'b1;
                end
`endif

                S_STOP: begin
                    // Returning to IDLE raises ready together with done, so a
                    // load on the done cycle starts the next frame at once.
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    x_out   <= 1'b1;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    done    <= 1'b1;
                end

                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    x_out   <= 1'b1;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
